// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 keyboard receiver with scan-code FIFO and CPU data/status registers
module ps2_kbd_ctrl #(
  parameter int FIFO_AW    = 4,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        kbd_sel,
  input  logic        kbd_read,
  input  logic        kbd_reg,
  input  logic        kbd_stall,
  output logic [31:0] kbd_data_out,
  output logic        kbd_irq
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t st_q, st_d;
  logic [1:0] ck_s_q, dt_s_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic fclk_q, fclk_d, fall, d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic push, err_set;
  logic [FIFO_AW:0] wp_q, rp_q, wp_d, rp_d;
  logic [7:0] mem_q [2**FIFO_AW];
  logic empty, full, acc, pop, wr, clr;
  logic err_q, ovf_q, irq_q;
  logic [7:0] head;
  assign d      = dt_s_q[1];
  assign fclk_d = (&filt_q) ? 1'b1 : (|filt_q) ? fclk_q : 1'b0;
  assign fall   = fclk_q & ~fclk_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      ck_s_q <= 2'b11;
      dt_s_q <= 2'b11;
      filt_q <= '1;
      fclk_q <= 1'b1;
    end else begin
      ck_s_q <= {ck_s_q[0], ps2_clk};
      dt_s_q <= {dt_s_q[0], ps2_data};
      filt_q <= {filt_q[FILTER_LEN-2:0], ck_s_q[1]};
      fclk_q <= fclk_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q   <= IDLE;
      bit_q  <= '0;
      byte_q <= '0;
      par_q  <= 1'b0;
      to_q   <= '0;
    end else begin
      st_q   <= st_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
      par_q  <= par_d;
      to_q   <= to_d;
    end
  end
  // The frame watchdog only runs mid-frame and is rearmed by every clock fall
  always_comb begin
    st_d    = st_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    par_d   = par_q;
    to_d    = '0;
    push    = 1'b0;
    err_set = 1'b0;
    if (st_q != IDLE) to_d = fall ? '0 : to_q + TW'(1);
    if (fall) begin
      case (st_q)
        IDLE: begin
          st_d  = d ? IDLE : DATA;
          bit_d = '0;
        end
        DATA: begin
          byte_d = {d, byte_q[7:1]};
          bit_d  = bit_q + 3'd1;
          st_d   = (bit_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d = ^byte_q ^ d;
          st_d  = STOP;
        end
        default: begin
          push    = d & par_q;
          err_set = ~(d & par_q);
          st_d    = IDLE;
        end
      endcase
    end else if (st_q != IDLE && to_q == TW'(TIMEOUT - 1)) begin
      st_d = IDLE;
      to_d = '0;
    end
  end
  assign empty = wp_q == rp_q;
  assign full  = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) && (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
  assign acc   = kbd_sel & kbd_read & ~kbd_stall;
  assign pop   = acc & ~kbd_reg & ~empty;
  assign clr   = acc & kbd_reg;
  assign wr    = push & (~full | pop);
  assign wp_d  = wp_q + {{FIFO_AW{1'b0}}, wr};
  assign rp_d  = rp_q + {{FIFO_AW{1'b0}}, pop};
  assign head  = empty ? 8'h00 : mem_q[rp_q[FIFO_AW-1:0]];
  always_ff @(posedge clk) if (wr) mem_q[wp_q[FIFO_AW-1:0]] <= byte_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      err_q <= err_set | (err_q & ~clr);
      ovf_q <= (push & full & ~pop) | (ovf_q & ~clr);
      irq_q <= wp_d != rp_d;
    end
  end
  assign kbd_irq      = irq_q;
  assign kbd_data_out = ~(kbd_sel & kbd_read) ? 32'h0 :
                        kbd_reg ? {28'h0, err_q, ovf_q, full, ~empty} : {23'h0, ~empty, head};
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed bench driving PS/2 frames and CPU reads into ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;
  localparam int FL = 8;
  localparam int TO = 2000;
  logic clk = 1'b0, rst = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic kbd_sel = 1'b0, kbd_read = 1'b0, kbd_reg = 1'b0, kbd_stall = 1'b0;
  logic [31:0] kbd_data_out;
  logic kbd_irq;
  int n_cmp = 0, n_bad = 0;
  ps2_kbd_ctrl #(.FIFO_AW(4), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kbd_sel(kbd_sel), .kbd_read(kbd_read), .kbd_reg(kbd_reg), .kbd_stall(kbd_stall),
    .kbd_data_out(kbd_data_out), .kbd_irq(kbd_irq)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic r, input logic [31:0] exp, input string tag);
    kbd_sel = 1'b1; kbd_read = 1'b1; kbd_reg = r;
    #1;
    check(tag, kbd_data_out, exp);
    @(posedge clk);
    #1;
    kbd_sel = 1'b0; kbd_read = 1'b0;
  endtask
  task automatic send_bit(input logic b, input logic g);
    ps2_data = b;
    cyc(2);
    if (g) begin
      ps2_clk = 1'b0; cyc(FL - 1);
      ps2_clk = 1'b1; cyc(10);
    end else cyc(8);
    ps2_clk = 1'b0; cyc(20);
    ps2_clk = 1'b1; cyc(10);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop, input logic g);
    send_bit(1'b0, g);
    for (int i = 0; i < 8; i++) send_bit(b[i], g);
    send_bit(~^b ^ flip, g);
    send_bit(stop, g);
    ps2_data = 1'b1;
  endtask
  initial begin
    cyc(4);
    check("reset_irq", {31'h0, kbd_irq}, 32'h0);
    rst = 1'b1;
    cyc(2);
    rd(1'b1, 32'h0, "reset_status");
    rd(1'b0, 32'h0, "reset_data");
    kbd_sel = 1'b1; kbd_reg = 1'b1; #1;
    check("no_read_zero", kbd_data_out, 32'h0);
    kbd_sel = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("single_irq", {31'h0, kbd_irq}, 32'h1);
    rd(1'b0, 32'h11C, "single_data");
    check("single_irq_clr", {31'h0, kbd_irq}, 32'h0);
    rd(1'b0, 32'h0, "single_empty");
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("par_irq", {31'h0, kbd_irq}, 32'h0);
    rd(1'b1, 32'h8, "par_status");
    rd(1'b1, 32'h0, "par_status_clr");
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    rd(1'b1, 32'h8, "stop_status");
    rd(1'b1, 32'h0, "stop_status_clr");
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    rd(1'b1, 32'h7, "ovf_status");
    for (int i = 0; i < 16; i++) rd(1'b0, 32'h100 + 32'(i), $sformatf("ovf_data%0d", i));
    rd(1'b0, 32'h0, "ovf_drained");
    rd(1'b1, 32'h0, "ovf_status_clr");
    check("ovf_irq", {31'h0, kbd_irq}, 32'h0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    kbd_sel = 1'b1; kbd_read = 1'b1; kbd_reg = 1'b0; kbd_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall_hold%0d", i), kbd_data_out, 32'h1F0);
      @(posedge clk);
      #1;
    end
    kbd_stall = 1'b0;
    #1;
    check("stall_commit", kbd_data_out, 32'h1F0);
    @(posedge clk);
    #1;
    kbd_sel = 1'b0; kbd_read = 1'b0;
    rd(1'b0, 32'h11C, "stall_next");
    rd(1'b0, 32'h0, "stall_empty");
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    check("glitch_irq", {31'h0, kbd_irq}, 32'h1);
    rd(1'b0, 32'h15A, "glitch_data");
    rd(1'b0, 32'h0, "glitch_once");
    rd(1'b1, 32'h0, "glitch_status");
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    cyc(TO + 20);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    rd(1'b0, 32'h129, "timeout_data");
    rd(1'b0, 32'h0, "timeout_empty");
    rd(1'b1, 32'h0, "timeout_status");
    send_frame(8'h33, 1'b0, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("pre_rst_irq", {31'h0, kbd_irq}, 32'h1);
    rst = 1'b0;
    cyc(1);
    check("rst_irq", {31'h0, kbd_irq}, 32'h0);
    kbd_sel = 1'b1; kbd_read = 1'b1; kbd_reg = 1'b1; #1;
    check("rst_status", kbd_data_out, 32'h0);
    kbd_reg = 1'b0; #1;
    check("rst_data", kbd_data_out, 32'h0);
    kbd_sel = 1'b0; kbd_read = 1'b0;
    rst = 1'b1;
    ps2_data = 1'b1;
    cyc(20);
    send_frame(8'h45, 1'b0, 1'b1, 1'b0);
    rd(1'b0, 32'h145, "post_rst_data");
    rd(1'b1, 32'h0, "post_rst_status");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
